// File: rtl/multicycle_cpu_if.sv
// Memory bus between the multicycle CPU (master) and its single-port memory (slave).
// A transfer completes on the rising edge where mem_req and mem_ready are both high.
interface multicycle_cpu_if #(
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [7:0]        mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_cpu.sv
// Four-register multicycle CPU: FETCH -> DECODE -> EXEC [-> MEM] over a single
// ready/request memory bus that shares instruction and data space.
module multicycle_cpu #(
  parameter int         DATA_W   = 16,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_cpu_if.master      bus,
  output logic [7:0]            pc,
  output logic                  halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_LDI   = 4'b1000;
  localparam logic [3:0] OP_JMP   = 4'b1001;
  localparam logic [3:0] OP_BEQ   = 4'b1010;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  state_t            state_q, state_d;
  logic [7:0]        pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] regs_q [4];
  logic [DATA_W-1:0] regs_d [4];

  logic [3:0]        opcode;
  logic [1:0]        rd_idx;
  logic [1:0]        rs_idx;
  logic [7:0]        imm;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] alu_res;
  logic              alu_we;
  logic              branch_taken;
  logic              is_mem_op;

  assign opcode    = ir_q[15:12];
  assign rd_idx    = ir_q[11:10];
  assign rs_idx    = ir_q[9:8];
  assign imm       = ir_q[7:0];
  assign rd_val    = regs_q[rd_idx];
  assign rs_val    = regs_q[rs_idx];
  assign is_mem_op = (opcode == OP_LOAD) || (opcode == OP_STORE);

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_regs
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          regs_q[gi] <= '0;
        end else begin
          regs_q[gi] <= regs_d[gi];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = (opcode == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC:   state_d = is_mem_op ? S_MEM : S_FETCH;
      S_MEM:    if (bus.mem_ready) state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------- ALU
  always_comb begin
    alu_we  = 1'b1;
    alu_res = rd_val;
    case (opcode)
      OP_ADD:  alu_res = rd_val + rs_val;
      OP_SUB:  alu_res = rd_val - rs_val;
      OP_AND:  alu_res = rd_val & rs_val;
      OP_OR:   alu_res = rd_val | rs_val;
      OP_XOR:  alu_res = rd_val ^ rs_val;
      OP_LDI:  alu_res = DATA_W'(imm);
      default: alu_we  = 1'b0;
    endcase
  end

  assign branch_taken = (opcode == OP_JMP) || ((opcode == OP_BEQ) && (rd_val == rs_val));

  // ---------------------------------------------------------------- datapath updates
  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    for (int i = 0; i < 4; i++) begin
      regs_d[i] = regs_q[i];
    end
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          ir_d = bus.mem_rdata[15:0];
          pc_d = pc_q + 8'd1;
        end
      end
      S_EXEC: begin
        if (alu_we) regs_d[rd_idx] = alu_res;
        // pc already points past this instruction; a taken branch replaces it
        if (branch_taken) pc_d = imm;
      end
      S_MEM: begin
        if (bus.mem_ready && (opcode == OP_LOAD)) regs_d[rd_idx] = bus.mem_rdata;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  // Bus outputs are gated by reset so they read as idle while reset is high,
  // independent of the clock.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 8'h00;
    bus.mem_wdata = '0;
    halted        = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_req  = 1'b1;
          bus.mem_addr = pc_q;
        end
        S_MEM: begin
          bus.mem_req  = 1'b1;
          bus.mem_addr = imm;
          if (opcode == OP_STORE) begin
            bus.mem_we    = 1'b1;
            bus.mem_wdata = rd_val;
          end
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign pc = pc_q;

  // Request and its qualifiers must not move while the memory is stalling us.
  a_bus_hold: assert property (@(posedge clk) disable iff (reset)
    (bus.mem_req && !bus.mem_ready) |=>
      (bus.mem_req && $stable(bus.mem_we) && $stable(bus.mem_addr) && $stable(bus.mem_wdata)));

  a_wdata_quiet: assert property (@(posedge clk) disable iff (reset)
    !bus.mem_we |-> (bus.mem_wdata == '0));

  a_halt_idle: assert property (@(posedge clk) disable iff (reset)
    halted |-> !bus.mem_req);

endmodule
